io_uart_bridge: RTL

- Memory-mapped I/O peripheral on the processor core's IO bus; consumes IO_port_ID / IO_write_data / IO_write_strobe / IO_read_strobe and drives IO_read_data.
- Contains a TX FIFO feeding an 8N1 UART serializer, and a UART deserializer feeding an RX FIFO.
- Exposes a status register so firmware can poll for room to transmit and for received data.

---
 rtl/io_uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 43 ++++
 rtl/io_uart_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants, status bit layout and FSM encodings for the IO-bus UART bridge.
package io_uart_pkg;

  localparam logic [7:0] OFS_TXDATA = 8'd0;
  localparam logic [7:0] OFS_STATUS = 8'd1;
  localparam logic [7:0] OFS_RXDATA = 8'd2;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_AVAIL  = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_OVF    = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop makes room for a same-cycle push when full.
module sync_fifo
  import io_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_uart_bridge.sv
// IO-bus mapped 8N1 UART: TXDATA/STATUS/RXDATA ports, TX and RX FIFOs, inline TX/RX FSMs.
module io_uart_bridge
  import io_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TX_DEPTH     = 8,
  parameter int         RX_DEPTH     = 4,
  parameter logic [7:0] BASE_PORT    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam int             CW       = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]     P_TX     = BASE_PORT + OFS_TXDATA;
  localparam logic [7:0]     P_ST     = BASE_PORT + OFS_STATUS;
  localparam logic [7:0]     P_RX     = BASE_PORT + OFS_RXDATA;

  logic tx_wr, st_rd, rx_rd;
  assign tx_wr = IO_write_strobe && (IO_port_ID == P_TX);
  assign st_rd = IO_read_strobe  && (IO_port_ID == P_ST);
  assign rx_rd = IO_read_strobe  && (IO_port_ID == P_RX);

  // ---------------- TX path ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg, tx_head;
  logic          tx_pop, tx_full, tx_fifo_empty, tx_bit_end;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_wr), .pop(tx_pop), .wdata(IO_write_data),
    .rdata(tx_head), .full(tx_full), .empty(tx_fifo_empty)
  );

  assign tx_bit_end = (tx_cnt == BIT_END);

  // STOP hands straight to START when more data is queued, so frames run back to back.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_fifo_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:
        if (tx_bit_end) begin
          if (!tx_fifo_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
          else tx_next = TX_IDLE;
        end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == TX_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
      if (tx_state != TX_DATA) tx_bit <= '0;
      else if (tx_bit_end)     tx_bit <= tx_bit + 1'b1;
      if (tx_pop)                              tx_shreg <= tx_head;
      else if (tx_state == TX_DATA && tx_bit_end) tx_shreg <= tx_shreg >> 1;
    end
  end

  // Decoded from state so an async reset forces the line high immediately.
  always_comb begin
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg, rx_head;
  logic          rx_s1, rx_s2, rx_prev, rx_brk;
  logic          rx_fall, rx_samp, rx_push, fe_set, rx_full, rx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_samp = (rx_state == RX_START) ? (rx_cnt == HALF_END) : (rx_cnt == BIT_END);

  // After a bad stop bit, rx_brk holds the FSM in STOP until the line returns high.
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    fe_set  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_samp) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_samp && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:
        if (rx_brk) begin
          if (rx_s2) rx_next = RX_IDLE;
        end else if (rx_samp) begin
          if (rx_s2) begin rx_push = 1'b1; rx_next = RX_IDLE; end
          else fe_set = 1'b1;
        end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_brk   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == RX_IDLE || rx_samp) ? '0 : rx_cnt + 1'b1;
      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_samp)        rx_bit <= rx_bit + 1'b1;
      if (rx_state == RX_DATA && rx_samp) rx_shreg <= {rx_s2, rx_shreg[7:1]};
      if (fe_set)                    rx_brk <= 1'b1;
      else if (rx_state != RX_STOP)  rx_brk <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_rd), .wdata(rx_shreg),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- Sticky flags / register read ----------------
  logic rx_ovf, frame_err, tx_ovf;
  logic [7:0] status;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      rx_ovf    <= (rx_push && rx_full && !rx_rd)  || (rx_ovf    && !st_rd);
      frame_err <= fe_set                          || (frame_err && !st_rd);
      tx_ovf    <= (tx_wr && tx_full && !tx_pop)   || (tx_ovf    && !st_rd);
    end
  end

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_fifo_empty && (tx_state == TX_IDLE);
    status[ST_RX_AVAIL]  = !rx_empty;
    status[ST_RX_OVF]    = rx_ovf;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_TX_OVF]    = tx_ovf;
  end

  always_comb begin
    IO_read_data = '0;
    if (reset && IO_read_strobe) begin
      if (IO_port_ID == P_ST)                   IO_read_data = status;
      else if (IO_port_ID == P_RX && !rx_empty) IO_read_data = rx_head;
    end
  end

  assign irq = !rx_empty;

endmodule
